// File: rtl/booth_arb_pkg.sv
// Shared types and defaults for the Booth multiplier arbiter.
// Holds the FSM state encoding and the round-robin index step used by rr_arbiter.
package booth_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int DEF_N    = 8;
   localparam int DEF_NREQ = 4;

   // Next index in the circular search; wraps before unused codes when nreq is not a power of 2.
   function automatic int rr_next(input int idx, input int nreq);
      return (idx + 1 >= nreq) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/booth_mul_arbiter_if.sv
// Request/response bus between the datapath clients and the shared multiplier.
// master drives requests and consumes products; slave is the arbiter.
interface booth_mul_arbiter_if
   import booth_arb_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = $clog2(NREQ)
);
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [2*N-1:0]    rsp_product;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_product
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_product
   );
endinterface

// File: rtl/Booth.sv
// Combinational signed radix-2 Booth multiplier, full 2N-bit product.
// Zero latency; no handshake.
module Booth #(
   parameter int N = 8
) (
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic [2*N-1:0] Mul
);
   logic signed [2*N-1:0] a_ext;
   logic signed [2*N-1:0] acc;
   logic                  prev;

   always_comb begin
      a_ext = {{N{A[N-1]}}, A};
      acc   = '0;
      prev  = 1'b0;
      for (int i = 0; i < N; i++) begin
         case ({B[i], prev})
            2'b01:   acc = acc + (a_ext <<< i);
            2'b10:   acc = acc - (a_ext <<< i);
            default: acc = acc;
         endcase
         prev = B[i];
      end
      Mul = acc;
   end
endmodule

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request after last_grant.
// Zero latency; grant is all zeros when nothing is requested.
module rr_arbiter
   import booth_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_grant,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  idx
);
   logic [IDW-1:0] cand;
   logic           found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = last_grant;
      for (int k = 0; k < NREQ; k++) begin
         cand = IDW'(rr_next(int'(cand), NREQ));
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end
endmodule

// File: rtl/booth_mul_arbiter.sv
// Shares one Booth multiplier among NREQ requesters; product valid one edge after accept.
// No new grant while a product is computing or waiting; the product holds until rsp_ready.
module booth_mul_arbiter
   import booth_arb_pkg::*;
#(
   parameter int N    = DEF_N,
   parameter int NREQ = DEF_NREQ,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic               clk,
   input  logic               rst,
   booth_mul_arbiter_if.slave bus,
   output logic               busy
);
   state_t            state;
   state_t            state_nxt;
   logic [IDW-1:0]    last_grant;
   logic [IDW-1:0]    grant_idx;
   logic [IDW-1:0]    id;
   logic [IDW-1:0]    rsp_id_q;
   logic [NREQ-1:0]   grant;
   logic [NREQ-1:0]   ready;
   logic [N-1:0]      op_a;
   logic [N-1:0]      op_b;
   logic [2*N-1:0]    mul;
   logic [2*N-1:0]    product_q;
   logic              accept;

   rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
      .req        (bus.req_valid),
      .last_grant (last_grant),
      .grant      (grant),
      .idx        (grant_idx)
   );

   Booth #(.N(N)) u_booth (
      .A   (op_a),
      .B   (op_b),
      .Mul (mul)
   );

   always_comb begin
      state_nxt = state;
      ready     = '0;
      case (state)
         IDLE: begin
            ready = grant;
            if (|grant) state_nxt = CALC;
         end
         CALC:    state_nxt = HOLD;
         HOLD:    if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign accept = (state == IDLE) && (|grant);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= IDW'(NREQ - 1);
         id         <= '0;
         op_a       <= '0;
         op_b       <= '0;
         rsp_id_q   <= '0;
         product_q  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            op_a       <= bus.req_a[int'(grant_idx)*N +: N];
            op_b       <= bus.req_b[int'(grant_idx)*N +: N];
            id         <= grant_idx;
            last_grant <= grant_idx;
         end
         // Response registers only move on CALC, so they stay frozen through HOLD.
         if (state == CALC) begin
            product_q <= mul;
            rsp_id_q  <= id;
         end
      end
   end

   assign bus.req_ready   = ready;
   assign bus.rsp_valid   = (state == HOLD);
   assign bus.rsp_id      = rsp_id_q;
   assign bus.rsp_product = product_q;
   assign busy            = (state != IDLE);
endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed and randomized checks of the shared Booth multiplier arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_booth_mul_arbiter;
   import booth_arb_pkg::*;

   localparam int N    = 8;
   localparam int NREQ = 4;

   logic clk = 1'b0;
   logic rst;
   logic busy;

   booth_mul_arbiter_if #(.N(N), .NREQ(NREQ)) bus ();

   booth_mul_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (bus),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      int          id;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] prod;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      compared++;
      mismatched++;
      $display("FAIL %s: bound expired", name);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
      bus.req_a[i*N +: N] = a;
      bus.req_b[i*N +: N] = b;
   endtask

   function automatic logic [15:0] exp_prod(input logic [7:0] a, input logic [7:0] b);
      int r;
      r = int'($signed(a)) * int'($signed(b));
      return r[15:0];
   endfunction

   // Called at posedge+1 right after an accept edge; waits for the product and consumes it.
   task automatic finish_txn(input int exp_id, input logic [15:0] exp_p);
      int n = 0;
      @(negedge clk);
      while (!bus.rsp_valid && n < 20) begin
         step();
         n++;
         @(negedge clk);
      end
      if (!bus.rsp_valid) begin
         fail_now("rsp_timeout");
      end else begin
         chk("rsp_latency", 32'(n), 32'd1);
         chk("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
         chk("rsp_product", 32'(bus.rsp_product), 32'(exp_p));
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
   endtask

   vec_t vecs[8];
   logic [7:0]  rr_a[4];
   logic [7:0]  rr_b[4];
   logic [15:0] rr_p[4];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{0, 8'd7,    8'hFD, 16'hFFEB};
      vecs[1] = '{1, 8'h80,   8'h80, 16'h4000};
      vecs[2] = '{2, 8'h80,   8'h7F, 16'hC080};
      vecs[3] = '{3, 8'h7F,   8'h7F, 16'h3F01};
      vecs[4] = '{0, 8'h00,   8'hFF, 16'h0000};
      vecs[5] = '{2, 8'hFF,   8'hFF, 16'h0001};
      vecs[6] = '{1, 8'd100,  8'hCE, 16'hEC78};
      vecs[7] = '{3, 8'd12,   8'd12, 16'h0090};
      rr_a = '{8'd5,  8'hFA,  8'd7,  8'hF8};
      rr_b = '{8'hF7, 8'd10,  8'd11, 8'hF4};
      rr_p = '{16'hFFD3, 16'hFFC4, 16'h004D, 16'h0060};

      rst           = 1'b1;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("reset_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("reset_rsp_product", 32'(bus.rsp_product), 32'd0);
      chk("reset_req_ready", 32'(bus.req_ready), 32'd0);

      // First transaction with 5 cycles of back-pressure and a request pending in HOLD.
      step();
      bus.req_valid = 4'b0001;
      set_op(0, 8'd7, 8'hFD);
      @(negedge clk);
      chk("first_ready", 32'(bus.req_ready), 32'h1);
      chk("first_busy_idle", 32'(busy), 32'd0);
      step();
      bus.req_valid = 4'b0010;
      set_op(1, 8'd3, 8'd4);
      @(negedge clk);
      chk("calc_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("calc_busy", 32'(busy), 32'd1);
      chk("calc_req_ready", 32'(bus.req_ready), 32'd0);
      step();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         chk("hold_rsp_id", 32'(bus.rsp_id), 32'd0);
         chk("hold_rsp_product", 32'(bus.rsp_product), 32'hFFEB);
         chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
         step();
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      chk("hold_release_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_release_ready", 32'(bus.req_ready), 32'd0);
      step();
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      chk("after_hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("after_hold_grant", 32'(bus.req_ready), 32'h2);
      step();
      bus.req_valid = '0;
      finish_txn(1, 16'h000C);

      // Table of single-requester transactions covering corner operands.
      foreach (vecs[i]) begin
         bus.req_valid = 4'(1 << vecs[i].id);
         set_op(vecs[i].id, vecs[i].a, vecs[i].b);
         @(negedge clk);
         chk("vec_ready", 32'(bus.req_ready), 32'(1 << vecs[i].id));
         step();
         bus.req_valid = '0;
         finish_txn(vecs[i].id, vecs[i].prod);
      end

      // All requesters continuously valid: grants 0,1,2,3,0 every 3 cycles.
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_op(i, rr_a[i], rr_b[i]);
      bus.req_valid = 4'b1111;
      bus.rsp_ready = 1'b1;
      for (int cyc = 0; cyc < 15; cyc++) begin
         int g;
         g = (cyc / 3) % 4;
         @(negedge clk);
         case (cyc % 3)
            0: chk("rr_grant", 32'(bus.req_ready), 32'(1 << g));
            1: begin
               chk("rr_calc_ready", 32'(bus.req_ready), 32'd0);
               chk("rr_calc_valid", 32'(bus.rsp_valid), 32'd0);
            end
            default: begin
               chk("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
               chk("rr_rsp_id", 32'(bus.rsp_id), 32'(g));
               chk("rr_rsp_product", 32'(bus.rsp_product), 32'(rr_p[g]));
            end
         endcase
         step();
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b0;

      // After requester 2 is served, 3 wins over 1.
      bus.req_valid = 4'b0100;
      set_op(2, 8'hFE, 8'd9);
      @(negedge clk);
      chk("prio_first", 32'(bus.req_ready), 32'h4);
      step();
      bus.req_valid = 4'b1010;
      set_op(1, 8'd3, 8'd4);
      set_op(3, 8'hF9, 8'hF9);
      finish_txn(2, 16'hFFEE);
      @(negedge clk);
      chk("prio_3_before_1", 32'(bus.req_ready), 32'h8);
      step();
      bus.req_valid = 4'b0010;
      finish_txn(3, 16'h0031);
      @(negedge clk);
      chk("prio_then_1", 32'(bus.req_ready), 32'h2);
      step();
      bus.req_valid = '0;
      finish_txn(1, 16'h000C);

      // Reset while the product is being computed.
      bus.req_valid = 4'b0001;
      set_op(0, 8'd9, 8'd9);
      @(negedge clk);
      step();
      bus.req_valid = '0;
      rst = 1'b1;
      step();
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_rsp_id", 32'(bus.rsp_id), 32'd0);
      chk("midrst_rsp_product", 32'(bus.rsp_product), 32'd0);
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) set_op(i, rr_a[i], rr_b[i]);
      bus.req_valid = 4'b1111;
      @(negedge clk);
      chk("midrst_last_grant", 32'(bus.req_ready), 32'h1);
      step();
      bus.req_valid = '0;
      finish_txn(0, 16'hFFD3);

      // Random traffic with back-pressure against a scoreboard.
      begin
         int          lg   = 0;
         bit          idle = 1'b1;
         int          done = 0;
         int          cyc  = 0;
         int          acc;
         logic [3:0]  vld  = '0;
         logic [3:0]  er;
         logic [7:0]  pa[4];
         logic [7:0]  pb[4];
         int          q_id[$];
         logic [15:0] q_p[$];

         while (done < 200 && cyc < 20000) begin
            @(negedge clk);
            er  = '0;
            acc = -1;
            if (idle) begin
               for (int k = 1; k <= 4; k++) begin
                  int c;
                  c = (lg + k) % 4;
                  if (acc < 0 && vld[c]) begin
                     acc   = c;
                     er[c] = 1'b1;
                  end
               end
            end
            chk("rand_ready", 32'(bus.req_ready), 32'(er));
            if (acc >= 0) begin
               q_id.push_back(acc);
               q_p.push_back(exp_prod(pa[acc], pb[acc]));
               lg   = acc;
               idle = 1'b0;
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
               if (q_id.size() == 0) begin
                  fail_now("rand_extra_rsp");
               end else begin
                  chk("rand_rsp_id", 32'(bus.rsp_id), 32'(q_id.pop_front()));
                  chk("rand_rsp_product", 32'(bus.rsp_product), 32'(q_p.pop_front()));
               end
               done++;
               idle = 1'b1;
            end
            step();
            cyc++;
            if (acc >= 0) vld[acc] = 1'b0;
            for (int k = 0; k < 4; k++) begin
               if (!vld[k] && $urandom_range(0, 2) == 0) begin
                  vld[k] = 1'b1;
                  pa[k]  = 8'($urandom);
                  pb[k]  = 8'($urandom);
                  set_op(k, pa[k], pb[k]);
               end
            end
            bus.req_valid = vld;
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
         end
         if (cyc >= 20000) fail_now("rand_cycle_budget");
         chk("rand_done", 32'(done), 32'd200);
         chk("rand_queue_empty", 32'(q_id.size()), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/booth_mul_arbiter.md
Name: booth_mul_arbiter

Overview:
Shares one combinational signed N-bit Booth multiplier (module Booth, ports A, B, Mul) between NREQ requesters. Round-robin arbitration with valid/ready handshakes on both sides. Grants one request at a time, latches its operands, registers the 2N-bit signed product and holds it until the consumer accepts it. Sits between the datapath clients and the single multiplier instance.

Parameters:
N, 8, operand width in bits; operands are two's-complement signed.
NREQ, 4, number of requesters; must be at least 2.
IDW, $clog2(NREQ), width of the requester ID.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  NREQ  per-requester request valid.
req_ready  out  NREQ  per-requester accept strobe; at most one bit high.
req_a  in  NREQ*N  packed operand A; requester i uses bits [i*N +: N].
req_b  in  NREQ*N  packed operand B; same packing as req_a.
rsp_valid  out  1  product valid.
rsp_ready  in  1  consumer accepts the product.
rsp_id  out  IDW  index of the requester that owns the product.
rsp_product  out  2N  signed product, A*B.
busy  out  1  high in every state except IDLE.

Behaviour:
- States:
  - IDLE: req_ready is combinational. One-hot to the round-robin winner among the asserted req_valid bits. All zeros if no request.
  - CALC: operands are held in op_a/op_b; the multiplier is evaluated.
  - HOLD: rsp_valid=1; outputs are stable.
- Transitions:
  - IDLE -> CALC on the edge where req_valid[w] && req_ready[w]. op_a, op_b and id are latched from requester w. last_grant <= w.
  - CALC -> HOLD unconditionally on the next edge. rsp_product <= Mul(op_a, op_b); rsp_id <= id.
  - HOLD -> IDLE on the edge where rsp_ready=1. Otherwise stay in HOLD with rsp_* unchanged.
- Latency: accept at edge k -> rsp_valid high after edge k+1. Minimum 3 cycles per transaction, because no new grant is issued in CALC or HOLD.
- Round-robin:
  - Search order is last_grant+1, last_grant+2, … modulo NREQ.
  - Reset value of last_grant is NREQ-1, so requester 0 has first priority.
  - A granted requester has the lowest priority for the next grant.
- Requester rule: once asserted, req_valid and its operands stay stable until req_ready. Dropping them earlier is a protocol violation; behaviour is undefined but must not corrupt state.
- Arithmetic: full-width signed product with no truncation or saturation. Example: (-128)*(-128) = 16384 = 16'h4000.
- req_ready is 0 in CALC and HOLD, even if req_valid bits are pending.
- A request arriving in HOLD while rsp_ready=1 is granted no earlier than the cycle after the return to IDLE.
- Reset, including mid-transaction, returns the block to this state on the next edge:
  - state=IDLE, last_grant=NREQ-1
  - rsp_valid=0, rsp_id=0, rsp_product=0
  - op_a=op_b=0, req_ready=0, busy=0
  - The in-flight transaction is dropped silently.
- NREQ not a power of 2: the modulo search skips the unused ID codes.

Decomposition:
- Package booth_arb_pkg holds:
  - state enum {IDLE, CALC, HOLD}
  - default N and NREQ
  - a helper function for the round-robin next-index computation.
- Sub-module rr_arbiter(NREQ) is combinational: inputs are the req vector and last_grant; outputs are a one-hot grant and the encoded index.
- The Booth multiplier is instantiated once, unchanged, with A=op_a and B=op_b.

Test Plan:
- Reset, then req_valid=4'b0001 with a=8'd7, b=-8'd3 -> req_ready=0001 in the same cycle; rsp_valid two edges later with rsp_id=0, product=16'hFFEB (-21). Hold rsp_ready=0 for 5 cycles -> outputs unchanged and req_ready=0.
- All four requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles; products match A*B per ID.
- Corner operands (-128,-128), (-128,127), (127,127), (0,-1) -> 16'h4000, 16'hC080, 16'h3F01, 16'h0000.
- After requester 2 is served, requesters 1 and 3 both valid -> 3 granted before 1.
- Assert rst during CALC -> next edge: state IDLE, rsp_valid=0, last_grant=3. The subsequent request from 0 is served normally.
- 200 random (A,B,id) transactions with random rsp_ready back-pressure -> scoreboard matches signed product and ID for every response; none lost or duplicated.
